// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, flag indices and result record shared by the ALU result stage
//
// Contents:
//   OP_ADD/OP_ADD1/OP_SUB/OP_SUB1  legal ALU op codes
//   FLAG_N/FLAG_Z/FLAG_C/FLAG_V    bit positions inside a {N,Z,C,V} nibble
//   alu_res_t                      one queued result {op, data, nzcv}
//   is_legal_op()                  true for op codes 0000..0011
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADD1 = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUB1 = 4'b0011;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] data;
    logic [3:0]  nzcv;
  } alu_res_t;

  // The four legal ops occupy exactly the codes with the top two bits clear.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - ALU-side input and result-side output handshake bundle
//
// Signals:
//   alu_valid/alu_ready   ALU result offered / stage can accept
//   alu_op, alu_out       op code and 32-bit result
//   alu_n/zero/carryout/overflow  ALU flags
//   res_valid/res_ready   FIFO head valid / consumer takes head
//   res_data, res_nzcv, res_op    head entry fields
// Modports:
//   master  environment side (drives ALU outputs and res_ready)
//   slave   result stage side
interface alu_result_stage_if;

  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_n;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_nzcv;
  logic [3:0]  res_op;

  modport master (
    output alu_valid, alu_op, alu_out, alu_carryout, alu_overflow, alu_zero, alu_n,
    output res_ready,
    input  alu_ready, res_valid, res_data, res_nzcv, res_op
  );

  modport slave (
    input  alu_valid, alu_op, alu_out, alu_carryout, alu_overflow, alu_zero, alu_n,
    input  res_ready,
    output alu_ready, res_valid, res_data, res_nzcv, res_op
  );

endinterface

// File: rtl/alu_res_fifo.sv
// rtl/alu_res_fifo.sv - DEPTH-entry synchronous FIFO of alu_res_t records
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (empties and zeroes storage)
//   push        write push_data at the tail (ignored when full)
//   push_data   record to enqueue
//   pop         advance the head (ignored when empty)
//   head        registered head record
//   full, empty occupancy flags
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_res_t push_data,
  input  logic     pop,
  output alu_res_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  alu_res_t    mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so the head reads as all-zero straight after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registers ALU results into a FIFO and keeps NZCV, overflow count and illegal-op state
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           alu_result_stage_if.slave: ALU input handshake and result output handshake
//   clr_status    zero status_nzcv, ovf_count and illegal_op (wins over a same-cycle accept)
//   status_nzcv   {N,Z,C,V} of the most recent legal accepted op
//   ovf_count     saturating count of legal accepts with V=1
//   illegal_op    sticky flag for an accepted op outside 0000..0011
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_stage_if.slave    bus,
  input  logic                 clr_status,
  output logic [3:0]           status_nzcv,
  output logic [CNT_W-1:0]     ovf_count,
  output logic                 illegal_op
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic     full;
  logic     empty;
  logic     accept;
  logic     legal;
  logic     push;
  logic     pop;
  logic [3:0] in_nzcv;
  alu_res_t push_data;
  alu_res_t head;

  assign in_nzcv   = {bus.alu_n, bus.alu_zero, bus.alu_carryout, bus.alu_overflow};
  assign accept    = bus.alu_valid && !full;
  assign legal     = is_legal_op(bus.alu_op);
  // Illegal ops are consumed but never enqueued.
  assign push      = accept && legal;
  assign pop       = !empty && bus.res_ready;
  assign push_data = '{op: bus.alu_op, data: bus.alu_out, nzcv: in_nzcv};

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign bus.alu_ready = !full;
  assign bus.res_valid = !empty;
  assign bus.res_data  = head.data;
  assign bus.res_nzcv  = head.nzcv;
  assign bus.res_op    = head.op;

  // clr_status outranks the accept: the entry is still queued by the FIFO,
  // but its flags, overflow event and illegal marking are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_nzcv <= '0;
      ovf_count   <= '0;
      illegal_op  <= 1'b0;
    end else if (clr_status) begin
      status_nzcv <= '0;
      ovf_count   <= '0;
      illegal_op  <= 1'b0;
    end else if (accept) begin
      if (legal) begin
        status_nzcv <= in_nzcv;
        if (in_nzcv[FLAG_V] && (ovf_count != CNT_MAX)) begin
          ovf_count <= ovf_count + 1'b1;
        end
      end else begin
        illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed and randomized bench for alu_result_stage against a queue-based model
module tb_alu_result_stage;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic [3:0]  nzcv;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_status = 1'b0;
  logic [3:0]       status_nzcv;
  logic [CNT_W-1:0] ovf_count;
  logic             illegal_op;

  alu_result_stage_if bus ();

  alu_result_stage #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .clr_status  (clr_status),
    .status_nzcv (status_nzcv),
    .ovf_count   (ovf_count),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  ent_t       mq[$];
  logic [3:0] m_status;
  int         m_ovf;
  logic       m_illegal;
  logic       m_zero_head;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("res_valid", {31'b0, bus.res_valid}, {31'b0, mq.size() > 0});
    check("alu_ready", {31'b0, bus.alu_ready}, {31'b0, mq.size() < DEPTH});
    check("status_nzcv", {28'b0, status_nzcv}, {28'b0, m_status});
    check("ovf_count", {{(32-CNT_W){1'b0}}, ovf_count}, m_ovf);
    check("illegal_op", {31'b0, illegal_op}, {31'b0, m_illegal});
    if (mq.size() > 0) begin
      check("res_data", bus.res_data, mq[0].data);
      check("res_nzcv", {28'b0, bus.res_nzcv}, {28'b0, mq[0].nzcv});
      check("res_op", {28'b0, bus.res_op}, {28'b0, mq[0].op});
    end else if (m_zero_head) begin
      check("res_data_rst", bus.res_data, 32'h0);
      check("res_nzcv_rst", {28'b0, bus.res_nzcv}, 32'h0);
      check("res_op_rst", {28'b0, bus.res_op}, 32'h0);
    end
  endtask

  // One clock: drive inputs, advance the model with the rules of the stage, compare.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] out,
                      input logic [3:0] f, input logic rdy, input logic clr, input logic r);
    logic acc;
    logic pop;
    logic leg;
    bus.alu_valid    = v;
    bus.alu_op       = op;
    bus.alu_out      = out;
    bus.alu_n        = f[3];
    bus.alu_zero     = f[2];
    bus.alu_carryout = f[1];
    bus.alu_overflow = f[0];
    bus.res_ready    = rdy;
    clr_status       = clr;
    rst              = r;
    acc = v && (mq.size() < DEPTH);
    pop = rdy && (mq.size() > 0);
    leg = (op <= 4'd3);
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_status    = 4'h0;
      m_ovf       = 0;
      m_illegal   = 1'b0;
      m_zero_head = 1'b1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && leg) begin
        mq.push_back('{op: op, data: out, nzcv: f});
        m_zero_head = 1'b0;
      end
      if (clr) begin
        m_status  = 4'h0;
        m_ovf     = 0;
        m_illegal = 1'b0;
      end else if (acc) begin
        if (leg) begin
          m_status = f;
          if (f[0] && m_ovf < CNT_MAX) m_ovf++;
        end else begin
          m_illegal = 1'b1;
        end
      end
    end
    check_all();
  endtask

  initial begin
    int sat_exp[5];
    logic [3:0] rop;
    sat_exp = '{1, 2, 3, 3, 3};
    m_status    = 4'h0;
    m_ovf       = 0;
    m_illegal   = 1'b0;
    m_zero_head = 1'b1;

    // Reset state.
    step(0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    step(0, 4'h0, 32'h0, 4'h0, 0, 0, 0);

    // Single add.
    step(1, 4'b0000, 32'h0000_0005, 4'b0000, 0, 0, 0);
    check("add_data_const", bus.res_data, 32'h5);
    step(0, 4'h0, 32'h0, 4'h0, 1, 0, 0);

    // Backpressure: sub (Z) and sub1 (N) fill the FIFO, a third offer is ignored.
    step(1, 4'b0010, 32'h0000_0000, 4'b0100, 0, 0, 0);
    step(1, 4'b0011, 32'hFFFF_FFFF, 4'b1000, 0, 0, 0);
    check("full_ready_const", {31'b0, bus.alu_ready}, 32'h0);
    step(1, 4'b0000, 32'h0000_0007, 4'b0000, 0, 0, 0);
    check("head_nzcv_sub", {28'b0, bus.res_nzcv}, 32'h4);
    step(0, 4'h0, 32'h0, 4'h0, 1, 0, 0);
    check("head_nzcv_sub1", {28'b0, bus.res_nzcv}, 32'h8);
    step(0, 4'h0, 32'h0, 4'h0, 1, 0, 0);

    // Illegal op.
    step(1, 4'b0111, 32'h1234_5678, 4'b1111, 0, 0, 0);
    check("illegal_const", {31'b0, illegal_op}, 32'h1);

    // Overflow saturation, draining continuously.
    step(0, 4'h0, 32'h0, 4'h0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b0000, 32'h8000_0000 + i, 4'b0001, 1, 0, 0);
      check("ovf_sat_const", {{(32-CNT_W){1'b0}}, ovf_count}, sat_exp[i]);
    end
    step(0, 4'h0, 32'h0, 4'h0, 1, 0, 0);

    // clr_status with a same-cycle overflowing add.
    step(1, 4'b0111, 32'h0, 4'h0, 1, 0, 0);
    step(1, 4'b0000, 32'h0000_0009, 4'b0001, 0, 1, 0);
    check("clr_push_v", {28'b0, bus.res_nzcv}, 32'h1);

    // Reset with two queued entries.
    step(1, 4'b0001, 32'h0000_000A, 4'b0010, 0, 0, 0);
    step(1, 4'b0000, 32'h0000_000B, 4'b0000, 1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      step($urandom_range(0, 3) != 0, rop, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the 32-bit combinational add/sub ALU (ops add, add1, sub, sub1).
- Registers each ALU result and its flags into a small FIFO with a valid/ready output handshake.
- Maintains the architectural NZCV status register and a saturating overflow-event counter.
- Provides the first clocked boundary after the ALU; consumers are writeback and the branch unit.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU outputs and op are valid this cycle.
- alu_ready  output  1  stage can accept; equals !full.
- alu_op  input  4  op code driven to the ALU this cycle.
- alu_out  input  32  ALU result.
- alu_carryout  input  1  ALU carry.
- alu_overflow  input  1  ALU overflow.
- alu_zero  input  1  ALU zero.
- alu_n  input  1  ALU negative.
- res_valid  output  1  FIFO head valid.
- res_ready  input  1  consumer takes head.
- res_data  output  32  head result.
- res_nzcv  output  4  head flags {N,Z,C,V}.
- res_op  output  4  head op code.
- clr_status  input  1  clear status_nzcv, ovf_count and illegal_op.
- status_nzcv  output  4  architectural flags of the most recent legal op.
- ovf_count  output  CNT_W  number of accepted ops with V=1; saturates.
- illegal_op  output  1  sticky; set when an op outside 0000..0011 is accepted.

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, read/write pointers 0, res_valid=0, res_data=0, res_nzcv=0, res_op=0, status_nzcv=0, ovf_count=0, illegal_op=0, alu_ready=1.
- Reset mid-operation discards all FIFO contents; no partial drain.
- Accept: alu_valid && alu_ready at an edge.
- Legal ops 0000 (add), 0001 (add1), 0010 (sub), 0011 (sub1):
  - Push {op, out, N,Z,C,V}; flags are taken from the ALU as given, with no recomputation (sub carries C=0).
- Illegal op (0100..1111): accepted (consumed) but not pushed; status_nzcv and ovf_count unchanged; illegal_op <= 1.
- Latency: a push into an empty FIFO makes res_valid=1 on the next cycle. Outputs are driven from registered FIFO head storage; there is no combinational path from the alu_* inputs to the res_* outputs.
- Pop: res_valid && res_ready at an edge; head advances.
- Full FIFO: alu_ready=0; ALU inputs are ignored even if alu_valid=1. A push and a pop in the same cycle while full is therefore impossible.
- Push and pop in the same cycle when neither empty nor full: count is unchanged and both pointers advance.
- Pop of the last entry with no push: res_valid=0 next cycle.
- Pointers wrap modulo DEPTH. Full/empty are tracked by an extra pointer bit.
- res_data, res_nzcv and res_op are held stable while res_valid=1 && res_ready=0.
- status_nzcv <= pushed flags on every legal accept, independent of drain.
- ovf_count increments on a legal accept with V=1 and saturates at 2^CNT_W-1 (no wrap).
- clr_status has priority over a same-cycle update: it zeroes status_nzcv, ovf_count and illegal_op, and the same-cycle accept's status effects are dropped. The FIFO push for that accept still occurs.
- clr_status does not touch the FIFO.

Decomposition:
- Package alu_pkg:
  - Op constants OP_ADD=4'b0000, OP_ADD1=4'b0001, OP_SUB=4'b0010, OP_SUB1=4'b0011.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Struct type alu_res_t {op[3:0], data[31:0], nzcv[3:0]}.
  - Function is_legal_op.
- One sub-module, alu_res_fifo: parameterised DEPTH synchronous FIFO of alu_res_t with push/pop/full/empty. The status register, counter and illegal-op logic stay in the top module.

Test Plan:
- Reset then single add: alu_op=0000, alu_out=32'h0000_0005, flags 0 -> next cycle res_valid=1, res_data=5, res_nzcv=0000, status_nzcv=0000.
- Backpressure, DEPTH=2, res_ready=0: push sub (out=0, Z=1) then sub1 (out=32'hFFFF_FFFF, N=1) -> alu_ready=0 after the second push; third alu_valid ignored. Raising res_ready pops nzcv 0100 then 1000; alu_ready returns to 1.
- Illegal op: alu_op=4'b0111 with alu_valid=1 -> no push, res_valid stays 0, illegal_op=1, status_nzcv unchanged.
- Overflow saturation, CNT_W=2: five add accepts with V=1 -> ovf_count sequence 1,2,3,3,3; status_nzcv V bit =1.
- clr_status in the same cycle as an add with V=1 -> status_nzcv=0, ovf_count=0, illegal_op=0; the entry is still pushed with nzcv bit V=1.
- rst asserted with 2 entries queued and res_ready=1 -> next cycle res_valid=0, alu_ready=1, all outputs 0.
